// File: rtl/sp_ram_arbiter_if.sv
// Bus bundle between two RAM requesters, the sp_ram_arbiter and a single-port RAM.
// slave: arbiter side; master: requester/RAM side.
interface sp_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                  p0_req_i;
    logic                  p0_gnt_o;
    logic [ADDR_WIDTH-1:0] p0_addr_i;
    logic                  p0_we_i;
    logic [BE_W-1:0]       p0_be_i;
    logic [DATA_WIDTH-1:0] p0_wdata_i;
    logic                  p0_rvalid_o;
    logic [DATA_WIDTH-1:0] p0_rdata_o;

    logic                  p1_req_i;
    logic                  p1_gnt_o;
    logic [ADDR_WIDTH-1:0] p1_addr_i;
    logic                  p1_we_i;
    logic [BE_W-1:0]       p1_be_i;
    logic [DATA_WIDTH-1:0] p1_wdata_i;
    logic                  p1_rvalid_o;
    logic [DATA_WIDTH-1:0] p1_rdata_o;

    logic                  ram_en_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic                  ram_we_o;
    logic [BE_W-1:0]       ram_be_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;

    modport slave (
        input  p0_req_i, p0_addr_i, p0_we_i, p0_be_i, p0_wdata_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        input  p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        output ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o,
        input  ram_rdata_i
    );

    modport master (
        output p0_req_i, p0_addr_i, p0_we_i, p0_be_i, p0_wdata_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        output p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        input  ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Fixed-priority (port 0 first) arbiter sharing one single-port RAM between two requesters.
// Define SP_RAM_ARB_STARVE_LIMIT_EN to force a port 1 grant after MAX_WAIT denied cycles.
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic             clk,
    input  logic             rst_i,
    sp_ram_arbiter_if.slave  bus
);
    localparam int BE_W = DATA_WIDTH / 8;

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_range
        $error("sp_ram_arbiter: MAX_WAIT must be within 1..255");
    end

    logic                  p0_gnt;
    logic                  p1_gnt;
    logic                  force_p1;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [DATA_WIDTH-1:0] wdata_mux;
    logic [BE_W-1:0]       be_mux;
    logic                  we_mux;
    logic [1:0]            resp_sel_d;  // {valid, port}
    logic [1:0]            resp_sel_q;

`ifdef SP_RAM_ARB_STARVE_LIMIT_EN
    localparam logic [7:0] WaitLimit = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_d;
    logic [7:0] wait_cnt_q;

    always_comb begin
        force_p1   = bus.p1_req_i & (wait_cnt_q == WaitLimit);
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (!bus.p1_req_i || p1_gnt) begin
            wait_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    always_comb begin
        force_p1 = 1'b0;
    end
`endif

    always_comb begin
        p0_gnt    = ~rst_i & bus.p0_req_i & ~force_p1;
        p1_gnt    = ~rst_i & bus.p1_req_i & (~bus.p0_req_i | force_p1);
        addr_mux  = '0;
        wdata_mux = '0;
        be_mux    = '0;
        we_mux    = 1'b0;
        if (p0_gnt) begin
            addr_mux  = bus.p0_addr_i;
            wdata_mux = bus.p0_wdata_i;
            be_mux    = bus.p0_be_i;
            we_mux    = bus.p0_we_i;
        end else if (p1_gnt) begin
            addr_mux  = bus.p1_addr_i;
            wdata_mux = bus.p1_wdata_i;
            be_mux    = bus.p1_be_i;
            we_mux    = bus.p1_we_i;
        end
        resp_sel_d = {p0_gnt | p1_gnt, p1_gnt};
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            resp_sel_q <= 2'b00;
        end else begin
            resp_sel_q <= resp_sel_d;
        end
    end

    // Response is gated by rst_i so a response in flight when reset rises is dropped.
    always_comb begin
        bus.p0_gnt_o    = p0_gnt;
        bus.p1_gnt_o    = p1_gnt;
        bus.ram_en_o    = p0_gnt | p1_gnt;
        bus.ram_addr_o  = addr_mux;
        bus.ram_wdata_o = wdata_mux;
        bus.ram_be_o    = be_mux;
        bus.ram_we_o    = we_mux;
        bus.p0_rvalid_o = ~rst_i & resp_sel_q[1] & ~resp_sel_q[0];
        bus.p1_rvalid_o = ~rst_i & resp_sel_q[1] &  resp_sel_q[0];
        bus.p0_rdata_o  = bus.p0_rvalid_o ? bus.ram_rdata_i : '0;
        bus.p1_rdata_o  = bus.p1_rvalid_o ? bus.ram_rdata_i : '0;
    end
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model of grants, responses and RAM contents.
module tb_sp_ram_arbiter;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int MW = 3;
`ifdef SP_RAM_ARB_STARVE_LIMIT_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    // Simple single-port RAM, one-cycle read latency
    logic [31:0] ram_mem [16];
    always @(posedge clk) begin
        if (bus.ram_en_o) begin
            if (bus.ram_we_o) begin
                for (int k = 0; k < 4; k++)
                    if (bus.ram_be_o[k]) ram_mem[bus.ram_addr_o[5:2]][8*k +: 8] <= bus.ram_wdata_o[8*k +: 8];
            end else begin
                bus.ram_rdata_i <= ram_mem[bus.ram_addr_o[5:2]];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Requester-side transactions
    logic        q [2];
    logic        w [2];
    logic [14:0] a [2];
    logic [3:0]  b [2];
    logic [31:0] d [2];
    bit          gdone [2];

    // Reference model state
    logic [31:0] ref_mem [16];
    bit          pend_v, pend_p, pend_we;
    logic [31:0] pend_d;
    int          wait_n;
    logic [31:0] obs_rd [2];
    int          n_g1;

    task automatic set_txn(input int p, input logic rq, input logic we, input logic [14:0] ad,
                           input logic [3:0] be, input logic [31:0] dat);
        q[p] = rq; w[p] = we; a[p] = ad; b[p] = be; d[p] = dat;
    endtask

    task automatic new_txn(input int p);
        set_txn(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                15'($urandom_range(0, 15) << 2), 4'($urandom_range(1, 15)), $urandom);
    endtask

    task automatic tick();
        bit          forced, e0, e1, ev0, ev1;
        int          gp;
        logic [31:0] ea, ed;
        logic [3:0]  eb;
        logic        ew;
        bus.p0_req_i = q[0]; bus.p0_we_i = w[0]; bus.p0_addr_i = a[0]; bus.p0_be_i = b[0]; bus.p0_wdata_i = d[0];
        bus.p1_req_i = q[1]; bus.p1_we_i = w[1]; bus.p1_addr_i = a[1]; bus.p1_be_i = b[1]; bus.p1_wdata_i = d[1];
        #4;
        forced = STARVE && q[1] && (wait_n == MW);
        e0 = !rst_i && q[0] && !forced;
        e1 = !rst_i && q[1] && (!q[0] || forced);
        gp = e1 ? 1 : 0;
        ea = 0; ed = 0; eb = 0; ew = 0;
        if (e0 || e1) begin
            ea = 32'(a[gp]); ed = d[gp]; eb = b[gp]; ew = w[gp];
        end
        check_eq("p0_gnt", 32'(bus.p0_gnt_o), 32'(e0));
        check_eq("p1_gnt", 32'(bus.p1_gnt_o), 32'(e1));
        check_eq("ram_en", 32'(bus.ram_en_o), 32'(e0 | e1));
        check_eq("ram_addr", 32'(bus.ram_addr_o), ea);
        check_eq("ram_wdata", bus.ram_wdata_o, ed);
        check_eq("ram_be", 32'(bus.ram_be_o), 32'(eb));
        check_eq("ram_we", 32'(bus.ram_we_o), 32'(ew));
        ev0 = !rst_i && pend_v && !pend_p;
        ev1 = !rst_i && pend_v && pend_p;
        check_eq("p0_rvalid", 32'(bus.p0_rvalid_o), 32'(ev0));
        check_eq("p1_rvalid", 32'(bus.p1_rvalid_o), 32'(ev1));
        if (!ev0) check_eq("p0_rdata_idle", bus.p0_rdata_o, 32'h0);
        else if (!pend_we) check_eq("p0_rdata", bus.p0_rdata_o, pend_d);
        if (!ev1) check_eq("p1_rdata_idle", bus.p1_rdata_o, 32'h0);
        else if (!pend_we) check_eq("p1_rdata", bus.p1_rdata_o, pend_d);
        if (bus.p0_rvalid_o) obs_rd[0] = bus.p0_rdata_o;
        if (bus.p1_rvalid_o) obs_rd[1] = bus.p1_rdata_o;
        if (bus.p1_gnt_o) n_g1++;
        @(posedge clk);
        if (rst_i) begin
            pend_v = 0;
            wait_n = 0;
        end else begin
            pend_v = e0 || e1;
            pend_p = e1;
            if (e0 || e1) begin
                pend_we = w[gp];
                pend_d  = ref_mem[a[gp][5:2]];
                if (w[gp])
                    for (int k = 0; k < 4; k++)
                        if (b[gp][k]) ref_mem[a[gp][5:2]][8*k +: 8] = d[gp][8*k +: 8];
            end
            wait_n = (!q[1] || e1) ? 0 : wait_n + 1;
        end
        gdone[0] = e0;
        gdone[1] = e1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        pend_v = 0; pend_p = 0; pend_we = 0; pend_d = 0; wait_n = 0; n_g1 = 0;
        obs_rd[0] = 0; obs_rd[1] = 0;
        set_txn(0, 1, 0, 15'h0, 4'hF, 0);
        set_txn(1, 1, 0, 15'h4, 4'hF, 0);
        rst_i = 1'b1;
        @(posedge clk); #1;

        // Reset with both requesting, then release
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        set_txn(0, 0, 0, 15'h0, 4'h0, 0);
        set_txn(1, 0, 0, 15'h0, 4'h0, 0);
        tick();

        // Port 0 write then read-back
        set_txn(0, 1, 1, 15'h10, 4'hF, 32'hDEADBEEF); tick();
        set_txn(0, 1, 0, 15'h10, 4'hF, 32'h0);        tick();
        set_txn(0, 0, 0, 15'h0, 4'h0, 32'h0);         tick();
        check_eq("p0_readback", obs_rd[0], 32'hDEADBEEF);

        // Conflict: both read, then port 0 drops
        set_txn(0, 1, 0, 15'h10, 4'hF, 0);
        set_txn(1, 1, 0, 15'h20, 4'hF, 0);
        repeat (4) tick();
        set_txn(0, 0, 0, 15'h0, 4'h0, 0);
        tick();
        set_txn(1, 0, 0, 15'h0, 4'h0, 0);
        tick();

        // Port 1 partial write over a preloaded word
        set_txn(1, 1, 1, 15'h20, 4'hF, 32'hAAAAAAAA); tick();
        set_txn(1, 1, 1, 15'h20, 4'h3, 32'h11223344); tick();
        set_txn(1, 1, 0, 15'h20, 4'hF, 32'h0);        tick();
        set_txn(1, 0, 0, 15'h0, 4'h0, 32'h0);         tick();
        check_eq("p1_be_merge", obs_rd[1], 32'hAAAA3344);

        // Continuous contention from a clean counter
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        set_txn(0, 1, 0, 15'h8, 4'hF, 0);
        set_txn(1, 1, 0, 15'hC, 4'hF, 0);
        n_g1 = 0;
        repeat (12) tick();
        check_eq("starve_p1_grants", 32'(n_g1), STARVE ? 32'd3 : 32'd0);

        // Reset right after a port 1 grant drops its response
        set_txn(0, 0, 0, 15'h0, 4'h0, 0);
        set_txn(1, 1, 0, 15'h20, 4'hF, 0);
        tick();
        set_txn(1, 0, 0, 15'h0, 4'h0, 0);
        rst_i = 1'b1; tick();
        rst_i = 1'b0; tick();
        set_txn(1, 1, 0, 15'h20, 4'hF, 0); tick();
        set_txn(1, 0, 0, 15'h0, 4'h0, 0);  tick();
        check_eq("p1_after_rst", obs_rd[1], 32'hAAAA3344);

        // Randomized traffic with occasional reset
        new_txn(0);
        new_txn(1);
        for (int i = 0; i < 400; i++) begin
            rst_i = ($urandom_range(0, 99) == 0);
            tick();
            for (int p = 0; p < 2; p++)
                if (gdone[p] || !q[p]) new_txn(p);
        end
        rst_i = 1'b0;
        set_txn(0, 0, 0, 15'h0, 4'h0, 0);
        set_txn(1, 0, 0, 15'h0, 4'h0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Two-port arbiter that shares one single-port RAM between two requesters: port 0 (core data side) and port 1 (AXI/debug side).
- Sits directly in front of sp_ram_wrap and drives its en/addr/wdata/we/be.
- Returns read data with a fixed one-cycle latency plus a response-valid strobe to whichever port was granted.
- Fixed priority to port 0; an optional starvation limiter guarantees port 1 progress.

Parameters:
- ADDR_WIDTH, 15, byte address width of RAM and both ports.
- DATA_WIDTH, 32, data width; BE width is DATA_WIDTH/8.
- MAX_WAIT, 8, consecutive denied cycles of port 1 before a forced grant (starvation feature only); legal range 1..255.

Ports:
- clk  in  1  clock
- rst_i  in  1  synchronous active-high reset
- p0_req_i  in  1  port 0 request
- p0_gnt_o  out  1  port 0 grant (combinational, same cycle as request)
- p0_addr_i  in  ADDR_WIDTH  port 0 byte address
- p0_we_i  in  1  port 0 write enable
- p0_be_i  in  DATA_WIDTH/8  port 0 byte enables
- p0_wdata_i  in  DATA_WIDTH  port 0 write data
- p0_rvalid_o  out  1  port 0 response valid
- p0_rdata_o  out  DATA_WIDTH  port 0 read data
- p1_req_i, p1_gnt_o, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i, p1_rvalid_o, p1_rdata_o: identical set for port 1
- ram_en_o  out  1  RAM enable
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after an enabled access

Interface decision: one clock, clk; reset rst_i is synchronous and active-high.

Behaviour:
Grant (combinational):
- At most one grant per cycle. p0_gnt_o and p1_gnt_o are never both high.
- Without forced grant: p0_gnt_o = p0_req_i; p1_gnt_o = p1_req_i & ~p0_req_i.
- Request is a request/grant handshake. A requester holds req and its payload stable until it sees gnt high.

RAM drive:
- ram_en_o = p0_gnt_o | p1_gnt_o.
- addr/wdata/we/be are muxed from the granted port.
- When no port is granted: ram_addr_o, ram_wdata_o and ram_be_o are driven to 0, and ram_we_o is 0.

Response:
- Registered resp_sel (2 bits: valid, port) captures the grant each cycle.
- px_rvalid_o is high exactly in the cycle after that port's grant, for both reads and writes.
- px_rdata_o = ram_rdata_i while that port's rvalid is high, otherwise 0.
- Back-to-back grants yield back-to-back rvalids; throughput is 1 access/cycle.

Reset:
- While rst_i is high: resp_sel is cleared, both rvalid outputs are 0, and the starvation counter is 0.
- Grants remain combinational, but rst_i forces both gnt to 0 and ram_en_o to 0.
- Reset asserted mid-transfer: a response pending from the cycle before reset is dropped (rvalid stays 0) and its requester must re-issue.

Boundary cases:
- Same port requesting every cycle is granted every cycle with no bubbles.
- Simultaneous requests with no forced grant: port 0 wins and port 1 waits with no grant.

Optional Feature:
- Macro: SP_RAM_ARB_STARVE_LIMIT_EN.
- With the macro defined:
  - An 8-bit wait counter increments each cycle p1_req_i is high and not granted.
  - The counter clears on p1 grant or when p1_req_i is low.
  - When the counter equals MAX_WAIT, port 1 is granted that cycle even if port 0 requests; p0_gnt_o is 0 in that cycle.
  - The counter returns to 0 on the following cycle.
- Without the macro: no counter is present, and pure fixed priority applies (port 1 can starve indefinitely).

Test Plan:
- Reset behaviour: assert rst_i for 3 cycles with both req high -> gnt, ram_en_o and rvalid all 0. Release -> p0 granted on the first cycle after release.
- Port 0 only: write 0xDEADBEEF to addr 0x10 with be=0xF, then read 0x10 -> grant same cycle; p0_rvalid_o one cycle later each time; read returns 0xDEADBEEF.
- Conflict: both ports request reads every cycle for 4 cycles -> p0 granted 4 times, p1 never granted, p1_rvalid_o stays 0. Drop p0 -> p1 granted the next cycle, rvalid the cycle after.
- Byte enables from port 1: write 0x11223344 with be=0x3 over a word preloaded with 0xAAAAAAAA, then read -> 0xAAAA3344 on p1_rdata_o.
- Starvation (macro on, MAX_WAIT=3): both request continuously -> p0 granted cycles 0-2, p1 forced cycle 3, p0 cycle 4, pattern repeats every 4 cycles. Macro off -> p1 never granted.
- Mid-operation reset: grant a p1 read at cycle N, assert rst_i at N+1 -> p1_rvalid_o stays 0 at N+1; normal operation resumes after release.
